dmem_bank_responder: RTL
========================

Name: dmem_bank_responder

Overview:
- Responder side of the local data-memory access interface driven by the load and store address generators.
- Owns one single-port DMEM bank.
- Arbitrates between one load requester and one store requester, and back-pressures the losing requester through its stall input.
- Returns load data through a fixed-latency read pipeline and reports when each stream has fully drained.

Parameters:
- DATA_W, 32, data word width.
- DEPTH, 1024, bank depth in words (power of two); IDX_W = log2(DEPTH).
- READ_LAT, 2, cycles from load grant to O_Ld_Valid (1..4).

Ports:
- clock  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- I_Ld_Req  in  1  load access request; held by the requester while O_Ld_Stall is high.
- I_Ld_Addr  in  address_t  load address.
- I_Ld_End  in  1  load stream end flag (one-cycle pulse).
- O_Ld_Stall  out  1  stall to load requester.
- O_Ld_Valid  out  1  load data valid.
- O_Ld_Data  out  DATA_W  load data.
- O_Ld_Done  out  1  pulse: load stream ended and read pipeline empty.
- I_St_Req  in  1  store access request; held by the requester while O_St_Stall is high.
- I_St_Addr  in  address_t  store address.
- I_St_Data  in  DATA_W  store data, valid with I_St_Req.
- I_St_End  in  1  store stream end flag (one-cycle pulse).
- O_St_Stall  out  1  stall to store requester.
- O_St_Done  out  1  pulse: store stream ended and last write committed.
- O_Busy  out  1  any request or read in flight.

Behaviour:
- Reset:
  - Asynchronous; all outputs 0.
  - Priority token R_Pri = LD.
  - Read pipeline valids cleared; end-pending flags cleared.
  - Array contents not reset.
  - Reset mid-stream discards in-flight reads; no O_Ld_Valid is produced for them.
- Arbitration (combinational):
  - O_Ld_Stall = I_St_Req & I_Ld_Req & (R_Pri==ST).
  - O_St_Stall = I_Ld_Req & I_St_Req & (R_Pri==LD).
  - Stall depends only on raw requests and the registered token. Requesters must not gate their request with stall.
  - Grant = request & ~own stall.
  - On a conflict cycle, R_Pri toggles to the losing port at the clock edge. Otherwise R_Pri is unchanged.
  - A stalled request is not served and must be held with the same address and data.
- Store:
  - Granted store writes mem[idx(I_St_Addr)] <= I_St_Data at that edge.
  - A load granted in a later cycle to the same index returns the new data.
- Load:
  - Granted load reads mem[idx(I_Ld_Addr)] at the grant edge.
  - The result shifts through READ_LAT-1 further stages.
  - O_Ld_Valid asserts exactly READ_LAT cycles after the grant cycle.
  - Returned data are in grant order; one result per grant; no bubbles inserted.
  - O_Ld_Data holds its last value when O_Ld_Valid=0.
- Indexing: idx(a) = a[IDX_W-1:0] (wraps modulo DEPTH) unless the optional feature is enabled.
- End tracking:
  - I_Ld_End sets R_Ld_EndPend.
  - O_Ld_Done pulses for one cycle on the first cycle where R_Ld_EndPend=1, no load grant is pending, and all pipeline valids are 0; this also clears R_Ld_EndPend.
  - I_St_End sets R_St_EndPend; O_St_Done pulses the cycle after it is set, provided no store is stalled; this also clears the flag.
  - End flags arriving in the same cycle as a grant count that grant as part of the stream.
  - A second End arriving while pending is absorbed; Done pulses once.
- O_Busy = I_Ld_Req | I_St_Req | any pipeline valid | R_Ld_EndPend | R_St_EndPend.

Optional Feature:
- Macro: DMEM_RANGE_CHK_EN.
- Defined:
  - An address >= DEPTH is out of range.
  - Out-of-range store: write suppressed, still granted.
  - Out-of-range load: granted, returns all-zero data with normal latency.
  - Adds output O_Range_Err, 1 bit, sticky, reset 0, set the cycle after the first out-of-range grant.
- Undefined: no range check, addresses wrap via idx(), O_Range_Err port absent.

Test Plan:
- Store-only stream of addresses 0,1,2,3 with data 0xA0..0xA3, then I_St_End -> O_St_Stall never high; O_St_Done pulses once, one cycle after End.
- Load addresses 0..3 after the stores (READ_LAT=2) -> O_Ld_Valid high in cycles g+2..g+5 with data 0xA0..0xA3; O_Ld_Done the cycle after the last valid.
- Both ports requesting for 4 cycles from reset -> grants LD,ST,LD,ST; stall alternates starting with O_St_Stall=1; no request lost.
- Store 0x55 to address 7, then load address 7 the next cycle -> returns 0x55.
- Reset asserted while two loads are in the pipeline -> O_Ld_Valid=0 immediately; no stale valid after reset release; R_Pri=LD.
- Load address DEPTH+3 with the range check enabled -> data 0 and O_Range_Err=1. With it disabled -> returns mem[3].

Source files
------------

// File: rtl/dmem_bank_responder.sv
// dmem_bank_responder
// Responder for one single-port DMEM bank shared by a load and a store
// requester. A rotating priority token settles conflicts, the losing side is
// stalled, and load data return through a fixed-latency read pipeline.
// End-of-stream flags are held until the stream has drained, then reported
// as one-cycle done pulses.
//
// Optional build macro: DMEM_RANGE_CHK_EN
//   When defined, addresses >= DEPTH are out of range. Out-of-range stores are
//   dropped and out-of-range loads return zero. The sticky O_Range_Err port is
//   added to flag the first such access.
//   When undefined, addresses wrap modulo DEPTH.
//
// Priority token (pri_q):
//   state  | meaning
//   PRI_LD | load wins the next load/store conflict (reset value)
//   PRI_ST | store wins the next load/store conflict

module dmem_bank_responder #(
    parameter int DATA_W   = 32,
    parameter int DEPTH    = 1024,
    parameter int READ_LAT = 2,
    parameter int ADDR_W   = 12
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              I_Ld_Req,
    input  logic [ADDR_W-1:0] I_Ld_Addr,
    input  logic              I_Ld_End,
    output logic              O_Ld_Stall,
    output logic              O_Ld_Valid,
    output logic [DATA_W-1:0] O_Ld_Data,
    output logic              O_Ld_Done,
    input  logic              I_St_Req,
    input  logic [ADDR_W-1:0] I_St_Addr,
    input  logic [DATA_W-1:0] I_St_Data,
    input  logic              I_St_End,
    output logic              O_St_Stall,
    output logic              O_St_Done,
`ifdef DMEM_RANGE_CHK_EN
    output logic              O_Range_Err,
`endif
    output logic              O_Busy
);

    localparam int IDX_W = $clog2(DEPTH);

    typedef enum logic {
        PRI_LD = 1'b0,
        PRI_ST = 1'b1
    } pri_e;

    pri_e               pri_q, pri_d;
    logic               conflict;
    logic               ld_gnt, st_gnt;
    logic               st_wr_en;
    logic [IDX_W-1:0]   ld_idx, st_idx;
    logic [DATA_W-1:0]  rd_word;

    logic [DATA_W-1:0]  mem [DEPTH];

    logic [READ_LAT-1:0] vld_q;
    logic [DATA_W-1:0]   dat_q [READ_LAT];

    logic ld_pend_q, ld_pend_d;
    logic st_pend_q, st_pend_d;
    logic ld_done, st_done;

    assign ld_idx = I_Ld_Addr[IDX_W-1:0];
    assign st_idx = I_St_Addr[IDX_W-1:0];

    // Stalls depend only on the raw requests and the registered token, so a
    // requester never sees its own stall feed back into its request.
    assign conflict   = I_Ld_Req & I_St_Req;
    assign O_Ld_Stall = conflict & (pri_q == PRI_ST);
    assign O_St_Stall = conflict & (pri_q == PRI_LD);
    assign ld_gnt     = I_Ld_Req & ~O_Ld_Stall;
    assign st_gnt     = I_St_Req & ~O_St_Stall;

`ifdef DMEM_RANGE_CHK_EN
    logic ld_oor, st_oor;
    logic err_q, err_d;

    assign ld_oor   = |I_Ld_Addr[ADDR_W-1:IDX_W];
    assign st_oor   = |I_St_Addr[ADDR_W-1:IDX_W];
    assign st_wr_en = st_gnt & ~st_oor;
    assign rd_word  = ld_oor ? '0 : mem[ld_idx];
    assign err_d    = err_q | (ld_gnt & ld_oor) | (st_gnt & st_oor);

    // Sticky range error, raised the cycle after the first bad grant.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) err_q <= 1'b0;
        else       err_q <= err_d;
    end

    assign O_Range_Err = err_q;
`else
    logic addr_hi_unused;

    assign addr_hi_unused = ^{I_Ld_Addr[ADDR_W-1:IDX_W], I_St_Addr[ADDR_W-1:IDX_W]};
    assign st_wr_en       = st_gnt;
    assign rd_word        = mem[ld_idx];
`endif

    // Next token: hand priority to the loser of a conflict, else hold.
    always_comb begin
        pri_d = pri_q;
        if (conflict) begin
            pri_d = (pri_q == PRI_LD) ? PRI_ST : PRI_LD;
        end
    end

    // Token register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) pri_q <= PRI_LD;
        else       pri_q <= pri_d;
    end

    // Bank write port; contents are deliberately not reset.
    always_ff @(posedge clock) begin
        if (st_wr_en) mem[st_idx] <= I_St_Data;
    end

    // Read pipeline: stage 0 samples the bank at the grant edge, later stages
    // only move data alongside a valid so the output word holds when idle.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            vld_q <= '0;
            for (int k = 0; k < READ_LAT; k++) dat_q[k] <= '0;
        end else begin
            vld_q[0] <= ld_gnt;
            if (ld_gnt) dat_q[0] <= rd_word;
            for (int k = 1; k < READ_LAT; k++) begin
                vld_q[k] <= vld_q[k-1];
                if (vld_q[k-1]) dat_q[k] <= dat_q[k-1];
            end
        end
    end

    assign O_Ld_Valid = vld_q[READ_LAT-1];
    assign O_Ld_Data  = dat_q[READ_LAT-1];

    // Done conditions and end-pending updates; a repeated End while pending
    // merges into the same flag so Done fires once.
    always_comb begin
        ld_done   = ld_pend_q & ~I_Ld_Req & ~(|vld_q);
        st_done   = st_pend_q & ~O_St_Stall;
        ld_pend_d = (ld_pend_q & ~ld_done) | I_Ld_End;
        st_pend_d = (st_pend_q & ~st_done) | I_St_End;
    end

    // End-pending flags.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ld_pend_q <= 1'b0;
            st_pend_q <= 1'b0;
        end else begin
            ld_pend_q <= ld_pend_d;
            st_pend_q <= st_pend_d;
        end
    end

    assign O_Ld_Done = ld_done;
    assign O_St_Done = st_done;
    assign O_Busy    = I_Ld_Req | I_St_Req | (|vld_q) | ld_pend_q | st_pend_q;

endmodule
